pc_sequencer: RTL and testbench

Owns the program counter register and sequences instruction fetch for the RISC core. Each cycle it selects the next PC from four sources: sequential PC+4, taken-branch target, JALR target, or trap vector. It runs a fetch handshake with instruction memory and honours datapath stall and halt requests. It also maintains a retired-instruction counter.

---
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects next PC, runs the instruction-fetch
// handshake, handles stall/halt and keeps the retired-instruction counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jalr,
  input  logic [31:0] jalr_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        trap_pulse,
  output logic        halted,
  output logic [31:0] instret
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;

  logic        retire;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_pc;

  always_comb begin
    seq_pc   = pc_q + 32'd4;
    retire   = (state_q == ST_FETCH) && imem_ready && !stall;
    redirect = jalr || branch_taken;
    // JALR outranks a simultaneous taken branch; its bit 0 is always cleared.
    target   = jalr ? (jalr_target & ~32'h1) : branch_target;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    trap_d    = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (retire) begin
          instret_d = instret_q + 32'd1;
          if (halt) begin
            state_d = ST_HALTED;
          end else if (redirect) begin
            if (target[1:0] != 2'b00) begin
              pc_d   = TRAP_VECTOR;
              trap_d = 1'b1;
            end else begin
              pc_d = target;
            end
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VECTOR;
      instret_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign pc_plus4    = seq_pc;
  assign imem_req    = (state_q == ST_FETCH);
  assign halted      = (state_q == ST_HALTED);
  assign instr_valid = retire;
  assign trap_pulse  = trap_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected {pc, instret} of every retire
// is queued by the stimulus and checked by a monitor on each instr_valid.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jalr;
  logic [31:0] jalr_target;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        trap_pulse;
  logic        halted;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jalr         (jalr),
    .jalr_target  (jalr_target),
    .halt         (halt),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .trap_pulse   (trap_pulse),
    .halted       (halted),
    .instret      (instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic expect_retire(input logic [31:0] epc, input logic [31:0] ecnt);
    exp_q.push_back({epc, ecnt});
  endtask

  task automatic clear_redirects;
    branch_taken  = 1'b0;
    branch_target = '0;
    jalr          = 1'b0;
    jalr_target   = '0;
    halt          = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0;
    stall = 1'b0;
    clear_redirects();
    fork
      begin : monitor
        logic [63:0] e;
        forever begin
          @(negedge clk);
          if (rst_n && instr_valid) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_retire_pc", pc, 32'hDEAD_BEEF);
            end else begin
              e = exp_q.pop_front();
              chk("retire_pc", pc, e[63:32]);
              chk("retire_imem_addr", imem_addr, e[63:32]);
              chk("retire_instret", instret, e[31:0]);
            end
          end
        end
      end
      begin : stimulus
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_trap", {31'b0, trap_pulse}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);

        // Test 1: boot idle cycle then sequential run
        rst_n = 1'b1;
        imem_ready = 1'b1;
        settle();
        chk("boot_imem_req", {31'b0, imem_req}, 32'h0);
        chk("boot_valid", {31'b0, instr_valid}, 32'h0);
        expect_retire(32'h0, 32'd0);
        expect_retire(32'h4, 32'd1);
        expect_retire(32'h8, 32'd2);
        expect_retire(32'hC, 32'd3);
        tick(); settle();
        chk("fetch_imem_req", {31'b0, imem_req}, 32'h1);
        tick(); tick(); tick();
        tick();

        // Test 2: three stall cycles at 0x10, redirect ignored
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        settle();
        chk("t1_pc", pc, 32'h10);
        chk("t1_instret", instret, 32'd4);
        for (int i = 0; i < 3; i++) begin
          if (i != 0) begin tick(); settle(); end
          chk("stall_pc", pc, 32'h10);
          chk("stall_valid", {31'b0, instr_valid}, 32'h0);
          chk("stall_instret", instret, 32'd4);
        end
        tick();
        stall = 1'b0;
        clear_redirects();
        expect_retire(32'h10, 32'd4);
        expect_retire(32'h14, 32'd5);
        expect_retire(32'h18, 32'd6);
        expect_retire(32'h1C, 32'd7);
        tick(); settle();
        chk("after_stall_pc", pc, 32'h14);
        tick(); tick(); tick();

        // Test 3: jalr beats branch, bit 0 cleared
        branch_taken = 1'b1;
        branch_target = 32'h80;
        jalr = 1'b1;
        jalr_target = 32'h41;
        settle();
        chk("pre_jalr_pc", pc, 32'h20);
        expect_retire(32'h20, 32'd8);
        tick();
        clear_redirects();
        settle();
        chk("jalr_pc", pc, 32'h40);
        chk("jalr_instret", instret, 32'd9);
        chk("jalr_no_trap", {31'b0, trap_pulse}, 32'h0);

        // Test 4: misaligned branch target traps
        branch_taken = 1'b1;
        branch_target = 32'h82;
        expect_retire(32'h40, 32'd9);
        tick();
        clear_redirects();
        settle();
        chk("trap_pc", pc, 32'h100);
        chk("trap_pulse_hi", {31'b0, trap_pulse}, 32'h1);
        chk("trap_instret", instret, 32'd10);
        expect_retire(32'h100, 32'd10);
        tick();

        // Test 5: imem not ready, redirect ignored
        imem_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h200;
        settle();
        chk("trap_pulse_lo", {31'b0, trap_pulse}, 32'h0);
        chk("wait_imem_req", {31'b0, imem_req}, 32'h1);
        for (int i = 0; i < 5; i++) begin
          if (i != 0) begin tick(); settle(); end
          chk("wait_pc", pc, 32'h104);
          chk("wait_valid", {31'b0, instr_valid}, 32'h0);
        end
        tick();
        imem_ready = 1'b1;
        clear_redirects();
        expect_retire(32'h104, 32'd11);
        tick(); settle();
        chk("ready_pc", pc, 32'h108);

        // Test 6: wrap at top of address space, then halt
        jalr = 1'b1;
        jalr_target = 32'hFFFF_FFFC;
        expect_retire(32'h108, 32'd12);
        tick();
        clear_redirects();
        settle();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_pc_plus4", pc_plus4, 32'h0);
        expect_retire(32'hFFFF_FFFC, 32'd13);
        tick();
        halt = 1'b1;
        settle();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc_plus4", pc_plus4, 32'h4);
        expect_retire(32'h0, 32'd14);
        tick();
        halt = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        for (int i = 0; i < 3; i++) begin
          if (i != 0) begin tick(); end
          settle();
          chk("halt_flag", {31'b0, halted}, 32'h1);
          chk("halt_imem_req", {31'b0, imem_req}, 32'h0);
          chk("halt_pc", pc, 32'h0);
          chk("halt_instret", instret, 32'd15);
          chk("halt_valid", {31'b0, instr_valid}, 32'h0);
        end

        // Reset exits halt; then reset again in the middle of a fetch
        rst_n = 1'b0;
        settle();
        chk("unhalt_halted", {31'b0, halted}, 32'h0);
        chk("unhalt_instret", instret, 32'h0);
        tick();
        rst_n = 1'b1;
        clear_redirects();
        imem_ready = 1'b1;
        expect_retire(32'h0, 32'd0);
        expect_retire(32'h4, 32'd1);
        tick(); tick(); tick();
        imem_ready = 1'b0;
        settle();
        chk("mid_pc", pc, 32'h8);
        chk("mid_instret", instret, 32'd2);
        chk("mid_imem_req", {31'b0, imem_req}, 32'h1);
        settle();
        rst_n = 1'b0;
        settle();
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_instret", instret, 32'h0);
        chk("async_rst_imem_req", {31'b0, imem_req}, 32'h0);
        tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
